// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux datapath between four requesters.
// Registers grant and select; a hold limit keeps one owner from starving others.
module mux_4x1_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] din,
  output logic [3:0]          gnt,
  output logic [1:0]          sel,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] hold_cnt;

  logic [3:0] others;
  logic [1:0] next_ptr;
  logic       release_c;
  logic       preempt_c;
  logic [2:0] idle_pick;
  logic [2:0] hand_pick;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] first_req(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In GRANT the registered sel always names the current owner.
  always_comb begin
    others    = req & ~(4'b0001 << sel);
    next_ptr  = sel + 2'd1;
    release_c = !req[sel];
    preempt_c = (hold_cnt == HOLD_LAST) && (|others);
    idle_pick = first_req(req, ptr);
    hand_pick = first_req(others, next_ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      ptr      <= 2'b00;
      hold_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            gnt      <= 4'b0001 << idle_pick[1:0];
            sel      <= idle_pick[1:0];
            hold_cnt <= 4'd0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_c || preempt_c) begin
            ptr <= next_ptr;
            // Hand over directly when another requester waits; sel keeps its value otherwise.
            if (hand_pick[2]) begin
              gnt      <= 4'b0001 << hand_pick[1:0];
              sel      <= hand_pick[1:0];
              hold_cnt <= 4'd0;
            end else begin
              gnt   <= 4'b0000;
              state <= IDLE;
            end
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    if (|gnt) dout = din[sel*DATA_W +: DATA_W];
    dout_valid = (|gnt) && req[sel];
    busy       = (state == GRANT);
  end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
Name: mux_4x1_rr_arbiter

Overview:
Round-robin arbiter and select sequencer that shares one 4:1 multiplexer datapath between four requesters. It registers grants, drives the 2-bit select that steers the existing 4:1 mux, and presents the granted requester's data with a valid flag. A hold limit prevents one requester from starving the others.

Parameters:
DATA_W, 8, width of each requester data word and of dout
MAX_HOLD, 4, maximum consecutive grant cycles while any other requester is waiting (legal range 1..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  4  request lines, bit k belongs to requester k
din  input  4*DATA_W  requester data, requester k at [k*DATA_W +: DATA_W]
gnt  output  4  one-hot grant, registered
sel  output  2  index of current owner, registered; drives the 4:1 mux select
dout  output  DATA_W  din slice selected by sel while granted, else 0
dout_valid  output  1  high when gnt is non-zero and req[sel] is high
busy  output  1  high in GRANT state

Behaviour:
- Reset (async, immediate, including mid-grant): state=IDLE, gnt=0000, sel=00, ptr=00, hold_cnt=0, busy=0, dout=0, dout_valid=0.
- ptr is the highest-priority index; search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- IDLE: at a clock edge with req!=0, grant the first set req bit in search order. Set gnt one-hot, sel=index, hold_cnt=0, go to GRANT. Latency from req sampled to gnt is one cycle. With req=0, stay in IDLE.
- GRANT, owner o, evaluated at each edge:
  - Release when req[o]==0. Preempt when hold_cnt==MAX_HOLD-1 and req has any bit other than o set.
  - Otherwise hold: hold_cnt increments and saturates at MAX_HOLD-1. With no other requester, the owner holds indefinitely.
  - On release or preempt, ptr=o+1 mod 4. At the same edge, pick the next owner from remaining req bits in the new search order, with o excluded. If one exists, grant it directly with no idle bubble and hold_cnt=0. Otherwise gnt=0000 and go to IDLE; sel keeps its last value.
  - If o is preempted and still requesting, it re-enters arbitration at the lowest priority on later edges.
- gnt is never multi-hot and never changes except at a clock edge or reset.
- dout and dout_valid are combinational from the registered sel and gnt plus the live req and din. dout=0 when gnt=0000.
- A requester that drops req mid-grant produces dout_valid=0 for that cycle. Its grant is removed at the next edge.
- The hold limit is measured in clock cycles: with contention, an owner keeps gnt for exactly MAX_HOLD cycles.
- Simultaneous requests are resolved purely by ptr. Ties cannot occur.

Test Plan:
- Reset, then req=0001, din[7:0]=8'h5A -> one edge later gnt=0001, sel=00, dout=8'h5A, dout_valid=1, busy=1.
- From reset (ptr=0), req=0110 held -> gnt=0010 for exactly 4 cycles, then gnt=0100 the next cycle with no gap, then back to 0010 after 4 more cycles.
- req=1000 alone for 20 cycles -> gnt=1000 held all 20 cycles; drop req -> gnt=0000 and busy=0 one edge later; next req=0001 grants 0001 (ptr=0 after wrap).
- req=1111 continuously -> grants rotate 0001, 0010, 0100, 1000, 0001, each held 4 cycles; dout tracks din[sel].
- Owner 2 drops req while req=0011 -> next edge gnt=1000? No: the search from ptr=3 wraps to 0 -> gnt=0001, sel=00.
- Assert rst mid-grant (gnt=0100) between clock edges -> gnt=0000, sel=00, dout_valid=0 immediately, without waiting for a clock edge.
